uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one uart_tx transmitter between NUM_REQ byte-stream requesters, for example the acoustics status, debug and ping-reply sources.
- Grants the line for a whole frame: the winner keeps it until it sends a byte with last=1, or until it goes silent for HOLD_TIMEOUT cycles.
- Sequences uart_tx through its tx_send / ready handshake, so only one character is ever in flight.

---
 rtl/uart_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_sched : round-robin, frame-locked sharing of one uart_tx           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int HOLD_TIMEOUT = 20000,
  parameter int GRANT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_send,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [GRANT_W-1:0]           grant_id,
  output logic                         frame_abort
);

  localparam logic [2:0] S_ARB        = 3'd0;
  localparam logic [2:0] S_SEND       = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_HOLD       = 3'd4;

  localparam logic [GRANT_W:0]   c_num_req      = (GRANT_W+1)'(NUM_REQ);
  localparam logic [GRANT_W-1:0] c_last_idx     = GRANT_W'(NUM_REQ-1);
  localparam logic [15:0]        c_timeout_last = 16'(HOLD_TIMEOUT-1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic [GRANT_W-1:0]   r_grant_id;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_busy;
  logic                 r_frame_abort;
  logic                 r_last_flag;
  logic [15:0]          r_timer;

  logic [DATA_BITS-1:0] w_data_arr [NUM_REQ];
  logic                 w_arb_found;
  logic [GRANT_W-1:0]   w_arb_idx;
  logic [GRANT_W:0]     w_cand;
  logic                 w_own_valid;
  logic                 w_accept;
  logic                 w_timeout;
  logic [GRANT_W-1:0]   w_acc_idx;
  logic [GRANT_W-1:0]   w_next_ptr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // Rotating priority search: first valid at or after r_rr_ptr, modulo NUM_REQ.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (GRANT_W+1)'(i);
      if (w_cand >= c_num_req) w_cand = w_cand - c_num_req;
      if (!w_arb_found && req_valid[w_cand[GRANT_W-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[GRANT_W-1:0];
      end
    end
  end

  assign w_own_valid = req_valid[r_grant_id];
  assign w_accept    = ((r_state == S_ARB) && w_arb_found) ||
                       ((r_state == S_HOLD) && w_own_valid);
  assign w_acc_idx   = (r_state == S_HOLD) ? r_grant_id : w_arb_idx;
  assign w_timeout   = (r_state == S_HOLD) && !w_own_valid && (r_timer == c_timeout_last);
  assign w_next_ptr  = (r_grant_id == c_last_idx) ? '0 : r_grant_id + GRANT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_ARB;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_frame_abort <= 1'b0;
      r_timer       <= '0;
      r_last_flag   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_abort <= 1'b0;
      if (w_accept) begin
        r_tx_data   <= w_data_arr[w_acc_idx];
        r_last_flag <= req_last[w_acc_idx];
        r_grant_id  <= w_acc_idx;
        r_busy      <= 1'b1;
      end
      case (r_state)
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (r_last_flag) begin
              r_rr_ptr <= w_next_ptr;
              r_busy   <= 1'b0;
            end else begin
              r_timer <= '0;
            end
          end
        end
        S_HOLD: begin
          if (!w_own_valid) begin
            if (w_timeout) begin
              r_frame_abort <= 1'b1;
              r_rr_ptr      <= w_next_ptr;
              r_busy        <= 1'b0;
            end else if (r_timer != '1) begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        S_ARB, S_SEND, S_WAIT_START: ;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARB:        if (w_arb_found) w_state_nxt = S_SEND;
      S_SEND:       if (tx_ready) w_state_nxt = S_WAIT_START;
      S_WAIT_START: if (!tx_ready) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:  if (tx_ready) w_state_nxt = r_last_flag ? S_ARB : S_HOLD;
      S_HOLD: begin
        if (w_own_valid)    w_state_nxt = S_SEND;
        else if (w_timeout) w_state_nxt = S_ARB;
      end
      default:      w_state_nxt = S_ARB;
    endcase
  end

  // Strobes are held off while reset is asserted so no phantom accept is seen.
  always_comb begin
    req_ready = '0;
    tx_send   = 1'b0;
    if (!reset) begin
      if (w_accept) req_ready[w_acc_idx] = 1'b1;
      tx_send = (r_state == S_SEND) && tx_ready;
    end
  end

  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign frame_abort = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_sched : scoreboard bench with a behavioural uart_tx stand-in    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_tx_sched;
  localparam int NUM_REQ      = 4;
  localparam int DATA_BITS    = 8;
  localparam int HOLD_TIMEOUT = 8;
  localparam int GRANT_W      = 2;
  localparam int CHAR_CYC     = 160;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_send;
  logic                         tx_ready;
  logic                         busy;
  logic [GRANT_W-1:0]           grant_id;
  logic                         frame_abort;

  uart_tx_sched #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS),
    .HOLD_TIMEOUT(HOLD_TIMEOUT), .GRANT_W(GRANT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy),
    .grant_id(grant_id), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0]  src_q [NUM_REQ][$];
  logic [7:0]  sb_q[$];
  int          acc_q[$];
  int          exp_acc[$];
  logic [8:0]  drv_e;
  logic [7:0]  exp_b;
  logic [NUM_REQ-1:0] rdy_n = '0;
  bit          send_seen = 0;
  bit          model_busy = 0;
  bit          hold_low = 0;
  int          ucnt = 0;
  int          n_send = 0;
  int          n_overlap = 0;
  int          n_onehot_viol = 0;
  int          n_abort = 0;

  task automatic push(input int idx, input logic [7:0] d, input logic l);
    src_q[idx].push_back({l, d});
  endtask

  // Requester sources: pop on the accept seen before the edge, then re-drive.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy_n[i]) begin
        if (src_q[i].size() > 0) begin
          drv_e = src_q[i].pop_front();
          sb_q.push_back(drv_e[7:0]);
          acc_q.push_back(i);
        end else begin
          check("ready_without_valid", 1, 0);
        end
      end
    end
    rdy_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        drv_e = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DATA_BITS +: DATA_BITS] = drv_e[7:0];
        req_last[i] = drv_e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_BITS +: DATA_BITS] = '0;
        req_last[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    rdy_n = req_ready;
    if ($countones(req_ready) > 1) n_onehot_viol++;
    if (frame_abort) n_abort++;
    if (tx_send) begin
      n_send++;
      if (model_busy) n_overlap++;
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_b = sb_q.pop_front();
        check("tx_byte", tx_data, exp_b);
      end
      send_seen = 1;
    end
  end

  // uart_tx stand-in: ready drops the cycle after tx_send, no reset input.
  always @(posedge clk) begin
    #1;
    if (send_seen) begin
      send_seen  = 0;
      model_busy = 1;
      ucnt       = CHAR_CYC;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) model_busy = 0;
    end
    tx_ready = !model_busy && !hold_low;
  end

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (srcs_empty() && sb_q.size() == 0 && !model_busy && !busy && !send_seen) break;
    end
    if (k >= 3000) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  // Returns at the negedge where tx_ready is first high again after a character.
  task automatic wait_char_done(input string tag);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy && !tx_ready) break;
    end
    if (k >= 50) check({tag, "_start_timeout"}, 0, 1);
    for (k = 0; k < CHAR_CYC + 50; k++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    if (k >= CHAR_CYC + 50) check({tag, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int s0;
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_data", tx_data, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_ready", req_ready, 0);
    check("rst_send", tx_send, 0);
    reset = 1'b0;

    // Single requester
    push(2, 8'h41, 1); exp_acc.push_back(2);
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_send_early", tx_send, 0);
    @(negedge clk);
    check("t1_send", tx_send, 1);
    check("t1_data", tx_data, 8'h41);
    check("t1_busy", busy, 1);
    wait_idle("t1");
    check("t1_busy_end", busy, 0);
    check("t1_grant", grant_id, 2);
    push(0, 8'h01, 1); push(3, 8'h03, 1);
    exp_acc.push_back(3); exp_acc.push_back(0);
    wait_idle("t1b");

    // Frame lock: requester 1 holds the line over requester 0
    push(1, 8'h21, 0); push(1, 8'h22, 0); push(1, 8'h23, 1); push(0, 8'h20, 1);
    exp_acc.push_back(1); exp_acc.push_back(1); exp_acc.push_back(1); exp_acc.push_back(0);
    wait_idle("t3");

    // Timeout inside a frame
    push(3, 8'h30, 0); exp_acc.push_back(3);
    wait_char_done("t4");
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_abort) break;
    end
    check("t4_abort_lat", k, 9);
    check("t4_abort_busy", busy, 0);
    @(negedge clk);
    check("t4_abort_pulse", frame_abort, 0);
    push(3, 8'h31, 1); push(0, 8'h02, 1);
    exp_acc.push_back(0); exp_acc.push_back(3);
    wait_idle("t4c");

    // Contention
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) begin
        push(i, 8'h10 + 8'(i), 1);
        exp_acc.push_back(i);
      end
    wait_idle("t2");

    // Valid arriving in the last hold cycle wins over the timeout
    push(3, 8'h32, 0); exp_acc.push_back(3);
    wait_char_done("t4b");
    repeat (7) @(negedge clk);
    push(3, 8'h33, 1); exp_acc.push_back(3);
    @(negedge clk);
    check("t4b_ready", req_ready, 4'b1000);
    check("t4b_abort0", frame_abort, 0);
    @(negedge clk);
    check("t4b_abort1", frame_abort, 0);
    wait_idle("t4b");

    // tx_ready held low on entry
    s0 = n_send;
    hold_low = 1;
    push(2, 8'h5A, 1); exp_acc.push_back(2);
    @(negedge clk);
    check("t5_ready", req_ready, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_send", tx_send, 0);
      check("t5_data_hold", tx_data, 8'h5A);
    end
    hold_low = 0;
    @(negedge clk);
    check("t5_send", tx_send, 1);
    wait_idle("t5");
    check("t5_pulses", n_send - s0, 1);

    // Reset while a character is on the line
    push(1, 8'h55, 1); exp_acc.push_back(1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy && !tx_ready) break;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push(0, 8'h77, 1); exp_acc.push_back(0);
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_grant", grant_id, 0);
    check("t6_data", tx_data, 0);
    check("t6_abort", frame_abort, 0);
    check("t6_send", tx_send, 0);
    check("t6_ready", req_ready, 0);
    reset = 1'b0;
    wait_idle("t6");

    check("end_send_count", n_send, acc_q.size());
    check("end_overlap", n_overlap, 0);
    check("end_onehot", n_onehot_viol, 0);
    check("end_abort_count", n_abort, 1);
    check("end_sb_empty", sb_q.size(), 0);
    check("end_acc_count", acc_q.size(), exp_acc.size());
    for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++)
      check($sformatf("grant_order_%0d", i), acc_q[i], exp_acc[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
